// File: rtl/mem_writer_if.sv
// Bundles the control, byte-stream and memory write-port signals of mem_writer.
// The master side drives requests and stream words; the slave side is the writer itself.
interface mem_writer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  abort;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output start, base_addr, len, abort, s_valid, s_data,
        input  s_ready, w_en, w_addr, w_data, busy, done, count
    );

    modport slave (
        input  start, base_addr, len, abort, s_valid, s_data,
        output s_ready, w_en, w_addr, w_data, busy, done, count
    );
endinterface

// File: rtl/mem_writer.sv
// Writes a counted burst of stream words to consecutive memory addresses.
// Every output is a register; a write appears one cycle after its handshake.
module mem_writer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    mem_writer_if.slave wr_if
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  s_ready_q, s_ready_d;
    logic                  w_en_q, w_en_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  handshake;
    logic [ADDR_WIDTH:0]   count_inc;

    assign handshake = wr_if.s_valid && s_ready_q;
    assign count_inc = count_q + COUNT_ONE;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
            w_en_q    <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            w_en_q    <= w_en_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Output registers are loaded from next-state values so they line up with state_q.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        count_d   = count_q;
        s_ready_d = 1'b0;
        w_en_d    = 1'b0;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_if.start && !wr_if.abort) begin
                    addr_d  = wr_if.base_addr;
                    len_d   = wr_if.len;
                    count_d = '0;
                    if (wr_if.len != '0) begin
                        state_d   = STREAM;
                        s_ready_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            STREAM: begin
                s_ready_d = 1'b1;
                if (handshake) begin
                    w_en_d   = 1'b1;
                    w_addr_d = addr_q;
                    w_data_d = wr_if.s_data;
                    addr_d   = addr_q + ADDR_ONE;
                    count_d  = count_inc;
                    if (count_inc == len_q) begin
                        state_d   = DONE;
                        s_ready_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
                // A same-cycle word is still written; abort only cancels what follows.
                if (wr_if.abort) begin
                    state_d   = IDLE;
                    s_ready_d = 1'b0;
                    done_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign wr_if.s_ready = s_ready_q;
    assign wr_if.w_en    = w_en_q;
    assign wr_if.w_addr  = w_addr_q;
    assign wr_if.w_data  = w_data_q;
    assign wr_if.busy    = busy_q;
    assign wr_if.done    = done_q;
    assign wr_if.count   = count_q;

endmodule

// File: tb/tb_mem_writer.sv
// Directed scenarios for mem_writer with hand-computed expected writes and flags.
module tb_mem_writer;

    localparam int AW = 16;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mem_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .wr_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.abort     = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
    endtask

    task automatic start_transfer(input logic [AW-1:0] base, input logic [AW:0] n);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.len       = n;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        vectors++;
        if ({bus.s_ready, bus.w_en, bus.w_addr, bus.w_data, bus.busy, bus.done, bus.count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: ready/wen/addr/data/busy/done/count = %b/%b/%h/%h/%b/%b/%0d, want all zero",
                     bus.s_ready, bus.w_en, bus.w_addr, bus.w_data, bus.busy, bus.done, bus.count);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if ({bus.busy, bus.s_ready} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_release_idle: busy/ready = %b/%b, want 0/0", bus.busy, bus.s_ready);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] words [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        logic [AW-1:0] addrs [4] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
        start_transfer(16'h1000, 17'd4);
        vectors++;
        if ({bus.s_ready, bus.busy, bus.w_en, bus.done, bus.count} !== {1'b1, 1'b1, 1'b0, 1'b0, 17'd0}) begin
            miscompares++;
            $display("[TB] FAIL basic_accept: ready/busy/wen/done/count = %b/%b/%b/%b/%0d, want 1/1/0/0/0",
                     bus.s_ready, bus.busy, bus.w_en, bus.done, bus.count);
        end
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = words[i];
            step();
            vectors++;
            if ({bus.w_en, bus.w_addr, bus.w_data, bus.done, bus.s_ready, bus.count} !==
                {1'b1, addrs[i], words[i], (i == 3), (i != 3), 17'(i + 1)}) begin
                miscompares++;
                $display("[TB] FAIL basic_write%0d: wen/addr/data/done/ready/count = %b/%h/%h/%b/%b/%0d, want 1/%h/%h/%b/%b/%0d",
                         i, bus.w_en, bus.w_addr, bus.w_data, bus.done, bus.s_ready, bus.count,
                         addrs[i], words[i], (i == 3), (i != 3), i + 1);
            end
        end
        bus.s_data = 8'hEE;
        step();
        bus.s_valid = 1'b0;
        vectors++;
        if ({bus.w_en, bus.done, bus.busy, bus.s_ready, bus.count} !== {4'b0000, 17'd4}) begin
            miscompares++;
            $display("[TB] FAIL basic_end: wen/done/busy/ready/count = %b/%b/%b/%b/%0d, want 0/0/0/0/4",
                     bus.w_en, bus.done, bus.busy, bus.s_ready, bus.count);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] words [3] = '{8'h01, 8'h02, 8'h03};
        logic [AW-1:0] addrs [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        start_transfer(16'hFFFE, 17'd3);
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = words[i];
            step();
            vectors++;
            if ({bus.w_en, bus.w_addr, bus.w_data, bus.done} !== {1'b1, addrs[i], words[i], (i == 2)}) begin
                miscompares++;
                $display("[TB] FAIL wrap_write%0d: wen/addr/data/done = %b/%h/%h/%b, want 1/%h/%h/%b",
                         i, bus.w_en, bus.w_addr, bus.w_data, bus.done, addrs[i], words[i], (i == 2));
            end
        end
        bus.s_valid = 1'b0;
        step();
        vectors++;
        if ({bus.busy, bus.count} !== {1'b0, 17'd3}) begin
            miscompares++;
            $display("[TB] FAIL wrap_end: busy/count = %b/%0d, want 0/3", bus.busy, bus.count);
        end
    endtask

    task automatic test_stall();
        logic          valids [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [DW-1:0] words  [3] = '{8'h11, 8'h22, 8'h33};
        logic [AW-1:0] addrs  [3] = '{16'h0200, 16'h0201, 16'h0202};
        int            n = 0;
        start_transfer(16'h0200, 17'd3);
        for (int k = 0; k < 7; k++) begin
            bus.s_valid = valids[k];
            bus.s_data  = valids[k] ? words[n] : 8'hFF;
            step();
            vectors++;
            if (valids[k]) begin
                if ({bus.w_en, bus.w_addr, bus.w_data, bus.done, bus.s_ready} !==
                    {1'b1, addrs[n], words[n], (n == 2), (n != 2)}) begin
                    miscompares++;
                    $display("[TB] FAIL stall_write%0d: wen/addr/data/done/ready = %b/%h/%h/%b/%b, want 1/%h/%h/%b/%b",
                             n, bus.w_en, bus.w_addr, bus.w_data, bus.done, bus.s_ready,
                             addrs[n], words[n], (n == 2), (n != 2));
                end
                n++;
            end else begin
                if ({bus.w_en, bus.done, bus.s_ready} !== 3'b001) begin
                    miscompares++;
                    $display("[TB] FAIL stall_cycle%0d: wen/done/ready = %b/%b/%b, want 0/0/1",
                             k, bus.w_en, bus.done, bus.s_ready);
                end
            end
        end
        bus.s_valid = 1'b0;
        step();
        vectors++;
        if ({bus.w_en, bus.busy, bus.count} !== {2'b00, 17'd3}) begin
            miscompares++;
            $display("[TB] FAIL stall_end: wen/busy/count = %b/%b/%0d, want 0/0/3", bus.w_en, bus.busy, bus.count);
        end
    endtask

    task automatic test_len_zero();
        start_transfer(16'h1234, 17'd0);
        vectors++;
        if ({bus.done, bus.busy, bus.w_en, bus.s_ready, bus.count} !== {4'b1100, 17'd0}) begin
            miscompares++;
            $display("[TB] FAIL len0_done: done/busy/wen/ready/count = %b/%b/%b/%b/%0d, want 1/1/0/0/0",
                     bus.done, bus.busy, bus.w_en, bus.s_ready, bus.count);
        end
        step();
        vectors++;
        if ({bus.done, bus.busy, bus.w_en} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL len0_end: done/busy/wen = %b/%b/%b, want 0/0/0", bus.done, bus.busy, bus.w_en);
        end
    endtask

    task automatic test_start_ignored();
        logic [DW-1:0] words [5] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
        logic [AW-1:0] addrs [5] = '{16'h3000, 16'h3001, 16'h3002, 16'h3003, 16'h3004};
        start_transfer(16'h3000, 17'd5);
        for (int i = 0; i < 5; i++) begin
            bus.s_valid   = 1'b1;
            bus.s_data    = words[i];
            bus.start     = (i == 2);
            bus.base_addr = 16'h5000;
            bus.len       = 17'd1;
            step();
            bus.start = 1'b0;
            vectors++;
            if ({bus.w_en, bus.w_addr, bus.w_data, bus.done, bus.count} !==
                {1'b1, addrs[i], words[i], (i == 4), 17'(i + 1)}) begin
                miscompares++;
                $display("[TB] FAIL busy_start_write%0d: wen/addr/data/done/count = %b/%h/%h/%b/%0d, want 1/%h/%h/%b/%0d",
                         i, bus.w_en, bus.w_addr, bus.w_data, bus.done, bus.count,
                         addrs[i], words[i], (i == 4), i + 1);
            end
        end
        bus.s_valid = 1'b0;
        step();
        vectors++;
        if ({bus.busy, bus.count} !== {1'b0, 17'd5}) begin
            miscompares++;
            $display("[TB] FAIL busy_start_end: busy/count = %b/%0d, want 0/5", bus.busy, bus.count);
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] words [3] = '{8'h40, 8'h41, 8'h42};
        logic [AW-1:0] addrs [3] = '{16'h4000, 16'h4001, 16'h4002};
        start_transfer(16'h4000, 17'd8);
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = words[i];
            step();
            vectors++;
            if ({bus.w_en, bus.w_addr, bus.w_data} !== {1'b1, addrs[i], words[i]}) begin
                miscompares++;
                $display("[TB] FAIL abort_write%0d: wen/addr/data = %b/%h/%h, want 1/%h/%h",
                         i, bus.w_en, bus.w_addr, bus.w_data, addrs[i], words[i]);
            end
        end
        bus.s_valid = 1'b0;
        bus.abort   = 1'b1;
        step();
        bus.abort = 1'b0;
        vectors++;
        if ({bus.s_ready, bus.busy, bus.done, bus.w_en, bus.count} !== {4'b0000, 17'd3}) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: ready/busy/done/wen/count = %b/%b/%b/%b/%0d, want 0/0/0/0/3",
                     bus.s_ready, bus.busy, bus.done, bus.w_en, bus.count);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h99;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({bus.w_en, bus.done, bus.count} !== {2'b00, 17'd3}) begin
                miscompares++;
                $display("[TB] FAIL abort_after%0d: wen/done/count = %b/%b/%0d, want 0/0/3",
                         i, bus.w_en, bus.done, bus.count);
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic test_abort_handshake();
        start_transfer(16'h6000, 17'd8);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h61;
        step();
        bus.s_data = 8'h5A;
        bus.abort  = 1'b1;
        step();
        bus.s_valid = 1'b0;
        vectors++;
        if ({bus.w_en, bus.w_addr, bus.w_data, bus.busy, bus.s_ready, bus.done, bus.count} !==
            {1'b1, 16'h6001, 8'h5A, 3'b000, 17'd2}) begin
            miscompares++;
            $display("[TB] FAIL abort_same_cycle: wen/addr/data/busy/ready/done/count = %b/%h/%h/%b/%b/%b/%0d, want 1/6001/5a/0/0/0/2",
                     bus.w_en, bus.w_addr, bus.w_data, bus.busy, bus.s_ready, bus.done, bus.count);
        end
        bus.start     = 1'b1;
        bus.base_addr = 16'h9000;
        bus.len       = 17'd2;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        vectors++;
        if ({bus.busy, bus.s_ready, bus.done, bus.count} !== {3'b000, 17'd2}) begin
            miscompares++;
            $display("[TB] FAIL abort_over_start: busy/ready/done/count = %b/%b/%b/%0d, want 0/0/0/2",
                     bus.busy, bus.s_ready, bus.done, bus.count);
        end
    endtask

    task automatic test_reset_mid();
        start_transfer(16'h7000, 17'd4);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h70;
        step();
        bus.s_data = 8'h71;
        bus.start  = 1'b1;
        bus.abort  = 1'b1;
        rst_n      = 1'b0;
        step();
        vectors++;
        if ({bus.s_ready, bus.w_en, bus.w_addr, bus.w_data, bus.busy, bus.done, bus.count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: ready/wen/addr/data/busy/done/count = %b/%b/%h/%h/%b/%b/%0d, want all zero",
                     bus.s_ready, bus.w_en, bus.w_addr, bus.w_data, bus.busy, bus.done, bus.count);
        end
        clear_inputs();
        rst_n = 1'b1;
        step();
        vectors++;
        if ({bus.w_en, bus.busy, bus.done} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_after: wen/busy/done = %b/%b/%b, want 0/0/0", bus.w_en, bus.busy, bus.done);
        end
    endtask

    task automatic test_full_length();
        logic [AW-1:0] exp_addr = 16'h0005;
        logic [DW-1:0] word;
        start_transfer(16'h0005, 17'h10000);
        for (int i = 0; i < 65536; i++) begin
            word        = exp_addr[7:0] ^ 8'h5A;
            bus.s_valid = 1'b1;
            bus.s_data  = word;
            step();
            vectors++;
            if ({bus.w_en, bus.w_addr, bus.w_data, bus.done} !== {1'b1, exp_addr, word, (i == 65535)}) begin
                miscompares++;
                $display("[TB] FAIL full_write%0d: wen/addr/data/done = %b/%h/%h/%b, want 1/%h/%h/%b",
                         i, bus.w_en, bus.w_addr, bus.w_data, bus.done, exp_addr, word, (i == 65535));
                break;
            end
            exp_addr = exp_addr + 16'h0001;
        end
        bus.s_valid = 1'b0;
        vectors++;
        if ({bus.w_addr, bus.count} !== {16'h0004, 17'h10000}) begin
            miscompares++;
            $display("[TB] FAIL full_last: addr/count = %h/%h, want 0004/10000", bus.w_addr, bus.count);
        end
        step();
        vectors++;
        if ({bus.w_en, bus.busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL full_end: wen/busy = %b/%b, want 0/0", bus.w_en, bus.busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clear_inputs();
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_len_zero();
        test_start_ignored();
        test_abort();
        test_abort_handshake();
        test_reset_mid();
        test_full_length();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
